// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: op encodings and multiply/divide unit states.
package mips_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    function automatic logic is_signed_op(input md_op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div_op(input md_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring subtract-shift divide.
module mdu_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic           ge;

    // Multiply: add multiplicand into upper half when LSB set, shift right.
    // Divide: shift {rem,quo} left, subtract divisor when it fits.
    always_comb begin
        sum    = '0;
        rem_sh = '0;
        ge     = 1'b0;
        hi_o   = hi_i;
        lo_o   = lo_i;
        if (is_div_i) begin
            rem_sh = {hi_i, lo_i[WIDTH-1]};
            ge     = (rem_sh >= {1'b0, opnd_i});
            hi_o   = ge ? WIDTH'(rem_sh - {1'b0, opnd_i}) : rem_sh[WIDTH-1:0];
            lo_o   = {lo_i[WIDTH-2:0], ge};
        end else begin
            sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
            hi_o = sum[WIDTH:1];
            lo_o = {sum[0], lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit with MTHI/MTLO access.
module mul_div_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);

    mdu_state_e       state_q;
    logic [CW-1:0]    count_q;
    md_op_e           op_q;
    logic             sa_q, sb_q, dz_q;
    logic [WIDTH-1:0] rs_orig_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH-1:0] acc_hi_q, acc_lo_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             busy_q, done_q, div0_q;

    md_op_e           op_in;
    logic             a_neg, b_neg, in_div;
    logic [WIDTH-1:0] abs_rs, abs_rt;
    logic [WIDTH-1:0] acc_lo_init, opnd_init;
    logic             accept;

    logic [WIDTH-1:0] step_hi, step_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rem;
    logic [WIDTH-1:0] hi_d, lo_d;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (is_div_op(op_q)),
        .hi_i     (acc_hi_q),
        .lo_i     (acc_lo_q),
        .opnd_i   (opnd_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo)
    );

    // Operand preparation for a newly accepted operation.
    always_comb begin
        op_in       = md_op_e'(op);
        in_div      = is_div_op(op_in);
        a_neg       = is_signed_op(op_in) & rs_val[WIDTH-1];
        b_neg       = is_signed_op(op_in) & rt_val[WIDTH-1];
        abs_rs      = a_neg ? -rs_val : rs_val;
        abs_rt      = b_neg ? -rt_val : rt_val;
        acc_lo_init = in_div ? abs_rs : abs_rt;
        opnd_init   = in_div ? abs_rt : abs_rs;
        accept      = start & ~busy_q;
    end

    // Sign correction and divide-by-zero override applied in FIX.
    always_comb begin
        prod = {acc_hi_q, acc_lo_q};
        quo  = acc_lo_q;
        rem  = acc_hi_q;
        if (sa_q ^ sb_q) begin
            prod = -prod;
            quo  = -quo;
        end
        if (sa_q) begin
            rem = -rem;
        end
        if (is_div_op(op_q)) begin
            if (dz_q) begin
                hi_d = rs_orig_q;
                lo_d = '1;
            end else begin
                hi_d = rem;
                lo_d = quo;
            end
        end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
        end
    end

    // Control FSM, iteration datapath and HI/LO registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            op_q      <= OP_MULT;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            dz_q      <= 1'b0;
            rs_orig_q <= '0;
            opnd_q    <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            div0_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        state_q   <= RUN;
                        busy_q    <= 1'b1;
                        count_q   <= '0;
                        op_q      <= op_in;
                        sa_q      <= a_neg;
                        sb_q      <= b_neg;
                        dz_q      <= in_div & (rt_val == '0);
                        rs_orig_q <= rs_val;
                        opnd_q    <= opnd_init;
                        acc_hi_q  <= '0;
                        acc_lo_q  <= acc_lo_init;
                    end else begin
                        state_q <= IDLE;
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                    end
                end
                RUN: begin
                    acc_hi_q <= step_hi;
                    acc_lo_q <= step_lo;
                    count_q  <= count_q + 1'b1;
                    if (count_q == CW'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    div0_q  <= dz_q;
                    busy_q  <= 1'b0;
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        busy, done, div0;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_err    = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .div0   (div0),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue an op (call at posedge+1), return after the edge that raises done.
    // At edge number inj a disturbing start + hi_we pulse is injected.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inj, output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        start   = 1'b1;
        op      = o;
        rs_val  = a;
        rt_val  = b;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                start = 1'b0;
                hi_we = 1'b0;
                lo_we = 1'b0;
            end
            if (k == inj) begin
                start  = 1'b1;
                op     = 2'd3;
                rs_val = 32'd999;
                rt_val = 32'd3;
                hi_we  = 1'b1;
                wdata  = 32'h0000_1234;
            end
            if (k == inj + 1) begin
                start = 1'b0;
                hi_we = 1'b0;
            end
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    initial begin
        int lat;
        bit bok;
        int done_seen;

        rst = 1'b1; start = 1'b0; op = 2'd0; rs_val = '0; rt_val = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_div0", div0, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);

        // MULTU max x max, latency and busy window
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, bok);
        check("multu_lat", lat, 34);
        check("multu_busy_window", bok, 1);
        check("multu_busy_at_done", busy, 0);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);
        check("multu_div0", div0, 0);

        // MULT -3 x 5, then DIV -7 / 2 started in the DONE cycle
        run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 0, lat, bok);
        check("mult_lat", lat, 34);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFF1);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, lat, bok);
        check("b2b_div_lat", lat, 34);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        check("done_pulse_width", done, 0);

        // DIVU by zero
        run_op(2'd3, 32'd100, 32'd0, 0, lat, bok);
        check("div0_lat", lat, 34);
        check("div0_flag", div0, 1);
        check("div0_lo", lo, 32'hFFFF_FFFF);
        check("div0_hi", hi, 32'h0000_0064);
        @(posedge clk); #1;
        check("div0_clear", div0, 0);

        // Signed overflow
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bok);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0000_0000);
        check("ovf_div0", div0, 0);

        // start and hi_we during RUN are ignored
        run_op(2'd1, 32'd3, 32'd4, 5, lat, bok);
        check("ign_lat", lat, 34);
        check("ign_hi", hi, 0);
        check("ign_lo", lo, 12);

        // MTHI while idle
        repeat (3) @(posedge clk);
        #1 hi_we = 1'b1; wdata = 32'h0000_1234;
        @(posedge clk); #1 hi_we = 1'b0;
        check("mthi_hi", hi, 32'h0000_1234);
        check("mthi_lo_kept", lo, 12);

        // MTLO while idle
        lo_we = 1'b1; wdata = 32'h0000_0055;
        @(posedge clk); #1 lo_we = 1'b0;
        check("mtlo_lo", lo, 32'h0000_0055);
        check("mtlo_hi_kept", hi, 32'h0000_1234);

        // hi_we coinciding with start is dropped
        hi_we = 1'b1; wdata = 32'h0000_ABCD;
        run_op(2'd1, 32'd1, 32'd1, 0, lat, bok);
        check("coinc_hi", hi, 0);
        check("coinc_lo", lo, 1);

        // Write nonzero HI/LO, then reset in the middle of a DIVU
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_7777;
        @(posedge clk); #1 hi_we = 1'b0; lo_we = 1'b0;
        start = 1'b1; op = 2'd3; rs_val = 32'd1000; rt_val = 32'd7;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        @(posedge clk); #1 rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check("arst_no_done", done_seen, 0);

        // MULTU after reset
        run_op(2'd1, 32'd6, 32'd7, 0, lat, bok);
        check("post_rst_lat", lat, 34);
        check("post_rst_lo", lo, 42);
        check("post_rst_hi", hi, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle HI/LO multiply/divide unit for the MIPS core, sitting directly downstream of the execute-stage sequencer. The sequencer issues MULT/MULTU/DIV/DIVU with a one-cycle `start` pulse and stalls on `busy`. The unit runs a radix-2 shift-add multiply or restoring divide over WIDTH iterations. It holds the 2×WIDTH result in HI/LO for MFHI/MFLO, and MTHI/MTLO write HI/LO directly when the unit is idle.

## Interface
- WIDTH, 32, operand width; iteration count equals WIDTH.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only when `busy`=0.
- op  input  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- rs_val  input  WIDTH  multiplicand or dividend.
- rt_val  input  WIDTH  multiplier or divisor.
- hi_we  input  1  MTHI: write `wdata` to HI.
- lo_we  input  1  MTLO: write `wdata` to LO.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  high in RUN and FIX.
- done  output  1  one-cycle pulse in DONE; HI/LO are valid from this cycle onward.
- div0  output  1  high with `done` when a divide had a zero divisor; low otherwise.
- hi  output  WIDTH  HI register: product upper half or remainder.
- lo  output  WIDTH  LO register: product lower half or quotient.

## Operation
- Reset:
  - Takes effect immediately, including mid-operation.
  - state=IDLE, count=0, hi=0, lo=0, busy=0, done=0, div0=0.
  - The operation in progress is discarded and no `done` is produced.
- State machine:
  - IDLE→RUN on `start`.
  - RUN→RUN while count≠WIDTH-1; RUN→FIX when count=WIDTH-1.
  - FIX→DONE.
  - DONE→RUN on `start`, else DONE→IDLE.
- Accepting `start` (IDLE or DONE):
  - Latch op and the operand sign flags.
  - For signed ops, replace each operand with its absolute value as unsigned WIDTH bits; 0x8000_0000 stays 0x8000_0000.
  - Set count=0.
- RUN: one iteration per cycle, count increments.
  - Multiply: conditional add into the upper half, then shift the 2×WIDTH accumulator right by 1.
  - Divide: shift {rem,quo} left by 1, trial-subtract the divisor from the WIDTH+1-bit remainder, set the quotient bit when the result is non-negative.
- FIX: sign-correct, then write HI/LO.
  - MULT: negate the 2×WIDTH product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Unsigned ops: no correction.
- Divide by zero (rt_val=0): lo=all ones, hi=original rs_val (not the absolute value), div0=1. The iterations still run, so latency is unchanged.
- Signed overflow, DIV 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0, div0=0.
- MTHI/MTLO:
  - `hi_we`/`lo_we` write on the next edge only when `busy`=0 and `start`=0.
  - Writes are dropped while busy or when they coincide with `start`; `start` has priority.
- `start` while busy: ignored, with no effect on the current operation.
- `hi`/`lo` hold their values except at the FIX→DONE edge, an MTHI/MTLO write, or reset.

## Timing
- Edge E0: `start` sampled. From E0 through E(WIDTH+1), `busy`=1.
- Edges E1..E(WIDTH): the WIDTH iterations.
- After E(WIDTH), state=FIX.
- Edge E(WIDTH+1): hi/lo written; `done` (and `div0` if applicable) high for exactly one cycle.
- Result latency: WIDTH+2 cycles, i.e. 34 for WIDTH=32.
- Back-to-back: a `start` in the DONE cycle begins the next operation, so throughput is one operation per WIDTH+2 cycles.
- Outputs are registered; no combinational path from inputs to `busy`, `done`, `hi`, or `lo`.

## Structure
- Shared package `mips_pkg`:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - mdu state enum: IDLE, RUN, FIX, DONE.
- Counter width: $clog2(WIDTH).
- One natural sub-module, `mdu_step`: a combinational single-iteration datapath (add-shift or subtract-shift) selected by op. The FSM, registers, and sign fix-up stay in `mul_div_unit`.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → hi=0xFFFF_FFFE, lo=0x0000_0001; `done` exactly 34 cycles after `start`; `busy` high for cycles 1-33.
- MULT −3 × 5 → hi=0xFFFF_FFFF, lo=0xFFFF_FFF1. Back-to-back DIV −7 / 2 issued in the DONE cycle → lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
- DIVU 100 / 0 → lo=0xFFFF_FFFF, hi=0x0000_0064, div0=1 with `done`. DIV 0x8000_0000 / 0xFFFF_FFFF → lo=0x8000_0000, hi=0, div0=0.
- `start` pulse and `hi_we` with wdata=0x1234 during RUN → both ignored; result unchanged. `hi_we` while idle → hi=0x1234 next cycle, lo unchanged.
- `rst` asserted asynchronously at cycle 10 of a DIVU → busy=0, hi=lo=0 immediately, no `done`. New MULTU 6 × 7 after reset → lo=42, hi=0.
